line_mem_responder: RTL and testbench
=====================================

# line_mem_responder

Main-memory side responder for cache line transfers. It accepts one line request at a time from the cache controller. A read streams the 8 words of a line (line fill). A write absorbs 8 words into the line (writeback). It drives port A of the single-port-latency main memory BRAM and sits between the cache's allocate/writeback engines and main memory.

## Interface
Parameters:
- DATA_W, 32, word width
- ADDR_W, 13, main-memory word address width (8192 words)
- WORDS_PER_LINE, 8, words per cache line (power of two)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  line request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = writeback, 0 = line fill
- req_addr  in  32  byte address; line base = req_addr[14:5], offset bits [4:0] ignored
- rd_valid  out  1  fill word valid
- rd_data  out  DATA_W  fill word
- rd_last  out  1  high with word 7
- rd_ready  in  1  consumer accepts word
- wr_valid  in  1  writeback word valid
- wr_data  in  DATA_W  writeback word
- wr_ready  out  1  high in WR state
- done  out  1  one-cycle pulse at end of transaction
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM word address
- mem_din  out  DATA_W  BRAM write data
- mem_dout  in  DATA_W  BRAM read data, 1-cycle latency
- mem_par_din  out  7  check bits written (ECC build only, else 0)
- mem_par_dout  in  7  check bits read (ECC build only, ignored otherwise)
- err_single  out  1  corrected single-bit error on current rd word
- err_double  out  1  uncorrectable error on current rd word

## Operation
- States: IDLE, RD_ISSUE, RD_DATA, WR, DONE. A 3-bit word counter `cnt` and a 10-bit latched line base are held.
- IDLE: req_ready=1. On req_valid: latch the base, set cnt=0, go to RD_ISSUE (read) or WR (write).
- RD_ISSUE: mem_addr={base,cnt}. Go to RD_DATA.
- RD_DATA: rd_valid=1, rd_data=mem_dout (corrected if ECC), mem_addr held so data stays stable while rd_ready=0. On handshake: if cnt==7 go to DONE, else cnt+1 and go to RD_ISSUE.
- WR: wr_ready=1. mem_we=wr_valid, mem_addr={base,cnt}, mem_din=wr_data, all combinational. On handshake: if cnt==7 go to DONE, else cnt+1. wr_valid low means no write and cnt holds.
- DONE: done=1 for one cycle, then IDLE.
- Counter wraps 7→0 only via DONE. A line never crosses the base; words go out in order 0..7 regardless of the req_addr offset.
- req_valid outside IDLE is ignored. rd_ready and wr_valid outside their states are ignored.
- Reset (including mid-transaction): state=IDLE and cnt=0 immediately. The partial line is abandoned. Reset output values: req_ready=1; rd_valid, rd_last, wr_ready, done, mem_we, err_single, err_double = 0; mem_addr=0; rd_data and mem_din = 0 or don't-care.

## Timing
- Request accepted at cycle T. For a read, word 0 is valid at T+2. Each later word is valid two cycles after the previous handshake. With rd_ready held high, word 7 is at T+16 and done at T+17.
- For a write with wr_valid held high, words are written at T+1..T+8 and done at T+9.
- req_ready returns high at done+1. A back-to-back request is accepted at done+1.
- err_single and err_double are valid only while rd_valid=1 and stay stable with the data.

## Configuration
- RESP_ECC_EN defined: the WR path encodes a (39,32) Hamming SECDED code onto mem_par_din. The RD path decodes mem_dout/mem_par_dout:
  - single error: data is corrected and err_single=1.
  - double error: raw data is passed through and err_double=1.
  - The transaction always continues.
- RESP_ECC_EN undefined: mem_par_din=0, mem_par_dout is ignored, err_single and err_double are tied 0, and rd_data=mem_dout.

## Structure
- Shared package `line_mem_pkg`: state enum, WORDS_PER_LINE, LINE_IDX_W=10, PAR_W=7, and syndrome-to-bit position constants.
- One sub-module, `secded_codec`, which is purely combinational and provides encode(data)→par and decode(data,par)→{data_c, single, double}. It is instantiated only under RESP_ECC_EN.

## Test plan
- Read req_addr=0x0000_0020, BRAM words 8..15 = 0x100..0x107, rd_ready=1: rd_data is 0x100..0x107 in order, rd_last on 0x107, done at T+17.
- Write req_addr=0x0000_7FE4, data 0xA0..0xA7: mem_we pulses at addresses 8184..8191 (offset ignored, base 1023), done at T+9.
- Read with rd_ready held low 5 cycles on word 3: rd_data is stable for those cycles, no skipped or duplicated words.
- rst_n deasserted in WR after 4 words: mem_we=0 and req_ready=1 immediately; a new read request is then served from word 0.
- RESP_ECC_EN: flip bit 5 of stored word 2 → corrected data with err_single=1. Flip bits 5 and 9 → raw data with err_double=1, and the fill still completes with done.

Source files
------------

// File: rtl/line_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_pkg
//  Description : Shared types and constants for the line memory responder:
//                FSM state encoding, line geometry and the (39,32) SECDED
//                codeword layout used by secded_codec.
//  Revision    : 1.0  initial release
// ============================================================================
package line_mem_pkg;

    // Responder FSM states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_IDX_W     = 10;
    localparam int PAR_W          = 7;

    // SECDED geometry: 32 data bits, 6 Hamming check bits, 1 overall parity
    localparam int ECC_DATA_W = 32;
    localparam int SYN_W      = 6;

    // Codeword position (1..38) of each data bit; powers of two are reserved
    // for the Hamming check bits, so a non-zero syndrome equal to one of these
    // entries names the data bit in error.
    localparam logic [SYN_W-1:0] DATA_POS [ECC_DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

endpackage
`default_nettype wire

// File: rtl/secded_codec.sv
`default_nettype none
// ============================================================================
//  Module      : secded_codec
//  Description : Purely combinational (39,32) Hamming SECDED encoder and
//                decoder. par[5:0] are Hamming check bits, par[6] is the
//                overall parity over data and par[5:0].
//  Revision    : 1.0  initial release
// ============================================================================
module secded_codec
    import line_mem_pkg::*;
(
    input  logic [ECC_DATA_W-1:0] enc_data,
    output logic [PAR_W-1:0]      enc_par,
    input  logic [ECC_DATA_W-1:0] dec_data,
    input  logic [PAR_W-1:0]      dec_par,
    output logic [ECC_DATA_W-1:0] dec_data_c,
    output logic                  dec_single,
    output logic                  dec_double
);

    logic [SYN_W-1:0] w_enc_hp;
    logic [SYN_W-1:0] w_syn;
    logic             w_overall;

    // Encoder: each check bit covers the data bits whose position has that bit set
    always_comb begin
        w_enc_hp = '0;
        for (int i = 0; i < ECC_DATA_W; i++) begin
            for (int j = 0; j < SYN_W; j++) begin
                if (DATA_POS[i][j]) begin
                    w_enc_hp[j] = w_enc_hp[j] ^ enc_data[i];
                end
            end
        end
    end

    assign enc_par = {^{enc_data, w_enc_hp}, w_enc_hp};

    // Decoder syndrome: recomputed check bits against the stored ones
    always_comb begin
        w_syn = dec_par[SYN_W-1:0];
        for (int i = 0; i < ECC_DATA_W; i++) begin
            for (int j = 0; j < SYN_W; j++) begin
                if (DATA_POS[i][j]) begin
                    w_syn[j] = w_syn[j] ^ dec_data[i];
                end
            end
        end
    end

    assign w_overall = ^{dec_data, dec_par};

    // Classify: odd overall parity means one flipped bit (fixable); even parity
    // with a non-zero syndrome means two flipped bits, data passed raw.
    always_comb begin
        dec_data_c = dec_data;
        dec_single = 1'b0;
        dec_double = 1'b0;
        if (w_overall) begin
            dec_single = 1'b1;
            for (int i = 0; i < ECC_DATA_W; i++) begin
                if (DATA_POS[i] == w_syn) begin
                    dec_data_c[i] = ~dec_data[i];
                end
            end
        end else if (w_syn != '0) begin
            dec_double = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_responder
//  Description : Main-memory side responder for cache line transfers. Serves
//                one line request at a time: a read streams the 8 words of a
//                line out of BRAM port A, a write absorbs 8 words into it.
//                Build option RESP_ECC_EN adds (39,32) SECDED protection on
//                the BRAM data (check bits on mem_par_din / mem_par_dout).
//  Revision    : 1.0  initial release
// ============================================================================
module line_mem_responder #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // line request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    // fill data stream
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    // writeback data stream
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              done,
    // BRAM port A
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [6:0]        mem_par_din,
    input  logic [6:0]        mem_par_dout,
    // ECC status of the word currently on rd_data
    output logic              err_single,
    output logic              err_double
);

    import line_mem_pkg::state_e;
    import line_mem_pkg::ST_IDLE;
    import line_mem_pkg::ST_RD_ISSUE;
    import line_mem_pkg::ST_RD_DATA;
    import line_mem_pkg::ST_WR;
    import line_mem_pkg::ST_DONE;

    localparam int CNT_W    = $clog2(WORDS_PER_LINE);
    localparam int BASE_W   = ADDR_W - CNT_W;
    // Byte-offset bits inside a line sit below the line index in req_addr
    localparam int BASE_LSB = CNT_W + $clog2(DATA_W / 8);
    localparam int BASE_MSB = BASE_LSB + BASE_W - 1;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WORDS_PER_LINE - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BASE_W-1:0]  r_base;

    logic [DATA_W-1:0]  w_rd_word;
    logic               w_err_single;
    logic               w_err_double;
    logic [6:0]         w_enc_par;
    logic               w_unused;

    // Transaction FSM: latch the line base, walk the word counter 0..N-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_base  <= req_addr[BASE_MSB:BASE_LSB];
                        r_cnt   <= '0;
                        r_state <= req_write ? ST_WR : ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rd_ready) begin
                        if (r_cnt == c_last_cnt) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_state <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_valid) begin
                        if (r_cnt == c_last_cnt) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from the state register,
    // so they take their reset values the moment rst_n falls.
    assign req_ready = (r_state == ST_IDLE);
    assign rd_valid  = (r_state == ST_RD_DATA);
    assign rd_last   = rd_valid && (r_cnt == c_last_cnt);
    assign wr_ready  = (r_state == ST_WR);
    assign done      = (r_state == ST_DONE);

    // The address is held through RD_DATA so the BRAM keeps re-reading the
    // same word and rd_data stays stable while the consumer stalls.
    assign mem_addr  = {r_base, r_cnt};
    assign mem_we    = wr_ready && wr_valid;
    assign mem_din   = wr_ready ? wr_data : '0;

    assign rd_data     = rd_valid ? w_rd_word : '0;
    assign err_single  = rd_valid && w_err_single;
    assign err_double  = rd_valid && w_err_double;
    assign mem_par_din = wr_ready ? w_enc_par : '0;

`ifdef RESP_ECC_EN
    secded_codec u_secded_codec (
        .enc_data   (wr_data),
        .enc_par    (w_enc_par),
        .dec_data   (mem_dout),
        .dec_par    (mem_par_dout),
        .dec_data_c (w_rd_word),
        .dec_single (w_err_single),
        .dec_double (w_err_double)
    );

    assign w_unused = ^{req_addr[31:BASE_MSB+1], req_addr[BASE_LSB-1:0]};
`else
    assign w_rd_word    = mem_dout;
    assign w_err_single = 1'b0;
    assign w_err_double = 1'b0;
    assign w_enc_par    = '0;

    assign w_unused = ^{req_addr[31:BASE_MSB+1], req_addr[BASE_LSB-1:0], mem_par_dout};
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_mem_responder
//  Description : Self-checking bench for line_mem_responder. A behavioural
//                BRAM with 1-cycle read latency sits on port A; a flat word
//                array is the reference image of main memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_ready;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        done;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [6:0]  mem_par_din;
    logic [6:0]  mem_par_dout;
    logic        err_single;
    logic        err_double;

    int n_vec = 0;
    int n_err = 0;

    // BRAM device and reference image of main memory
    logic [31:0] bram [0:8191];
    logic [6:0]  bpar [0:8191];
    logic [31:0] ref_mem [0:8191];

    // backdoor preload port and read-path fault injection
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [31:0] bd_data;
    logic [12:0] flip_addr;
    logic [31:0] flip_mask;

    // per-transaction expectations
    logic [31:0] exp_data [8];
    logic        exp_se   [8];
    logic        exp_de   [8];
    logic [31:0] wr_words [8];

    line_mem_responder #(
        .DATA_W         (32),
        .ADDR_W         (13),
        .WORDS_PER_LINE (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .done         (done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_par_din  (mem_par_din),
        .mem_par_dout (mem_par_dout),
        .err_single   (err_single),
        .err_double   (err_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference SECDED encoder: lay the data out in a 38-position Hamming
    // codeword, then take the parity of every position class.
    function automatic logic [6:0] model_ecc(input logic [31:0] d);
        logic [38:0] cw;
        logic [6:0]  p;
        int          di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        p = '0;
        for (int j = 0; j < 6; j++) begin
            for (int pos = 1; pos <= 38; pos++) begin
                if (pos[j]) p[j] = p[j] ^ cw[pos];
            end
        end
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    // BRAM: read-first, one cycle of read latency
    always @(posedge clk) begin
        if (bd_we) begin
            bram[bd_addr] <= bd_data;
            bpar[bd_addr] <= model_ecc(bd_data);
        end else if (mem_we) begin
            bram[mem_addr] <= mem_din;
            bpar[mem_addr] <= mem_par_din;
        end
        mem_dout     <= bram[mem_addr] ^ ((mem_addr == flip_addr) ? flip_mask : 32'h0);
        mem_par_dout <= bpar[mem_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_exp(input int base);
        for (int k = 0; k < 8; k++) begin
            exp_data[k] = ref_mem[base * 8 + k];
            exp_se[k]   = 1'b0;
            exp_de[k]   = 1'b0;
        end
    endtask

    // Preload lines 0..15; words 8..15 carry the 0x100.. fill pattern
    task automatic preload;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = 13'(i);
            bd_data = (i >= 8 && i < 16) ? 32'h100 + 32'(i - 8) : $urandom;
            ref_mem[i] = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Line fill. Caller is at a negedge; returns at the negedge after done.
    // mode 0: rd_ready high, 1: stall word 3 for 5 cycles, 2: random.
    task automatic do_read(input logic [31:0] addr, input int mode,
                           output int n_first0, output int n_last, output int n_done);
        int k;
        int n;
        int hold;
        k = 0; hold = 0; n_first0 = -1; n_last = -1; n_done = -1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_req_ready: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        @(negedge clk);
        n = 1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        while (n_done < 0 && n < 300) begin
            n_vec++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL rd_busy_ready: cycle %0d got %b want 0", n, req_ready);
            end
            if (k == 8) begin
                n_vec++;
                if (done !== 1'b1 || rd_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd_done: got done=%b rd_valid=%b want 1/0", done, rd_valid);
                end
                n_done = n;
            end else if (done === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_early_done: done after %0d words want 8", k);
                n_done = n;
            end else if (rd_valid === 1'b1) begin
                n_vec++;
                if (rd_data !== exp_data[k] || rd_last !== (k == 7) ||
                    err_single !== exp_se[k] || err_double !== exp_de[k]) begin
                    n_err++;
                    $display("FAIL rd_word k=%0d: got data=%h last=%b se=%b de=%b, want data=%h last=%b se=%b de=%b",
                             k, rd_data, rd_last, err_single, err_double,
                             exp_data[k], (k == 7), exp_se[k], exp_de[k]);
                end
                if (k == 0 && n_first0 < 0) n_first0 = n;
                if (k == 7 && n_last < 0) n_last = n;
                if (mode == 0) begin
                    rd_ready = 1'b1;
                end else if (mode == 1) begin
                    if (k == 3 && hold < 5) begin
                        rd_ready = 1'b0;
                        hold++;
                    end else begin
                        rd_ready = 1'b1;
                    end
                end else begin
                    rd_ready = 1'($urandom_range(0, 1));
                end
                if (rd_ready) k++;
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
            end
            if (mode == 2) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom_range(0, 1));
            end
            if (n_done < 0) begin
                @(negedge clk);
                n++;
            end
        end
        rd_ready = 1'b0; req_valid = 1'b0;
        if (n_done < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_timeout: got %0d words want 8", k);
        end
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rd_after_done: got req_ready=%b done=%b want 1/0", req_ready, done);
        end
    endtask

    // Writeback of wr_words[]. mode 0: wr_valid high, 2: random.
    // abort_after >= 0 returns at the negedge after that many words, in WR.
    task automatic do_write(input logic [31:0] addr, input int mode, input int abort_after,
                            output int n_first, output int n_lastw, output int n_done);
        int k;
        int n;
        int base;
        k = 0; n_first = -1; n_lastw = -1; n_done = -1;
        base = int'(addr[14:5]);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_req_ready: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; wr_valid = 1'b0;
        @(negedge clk);
        n = 1;
        req_valid = 1'b0;
        while (n_done < 0 && n < 300) begin
            if (abort_after >= 0 && k == abort_after) return;
            if (k == 8) begin
                wr_valid = 1'($urandom_range(0, 1));
                #1;
                n_vec++;
                if (done !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_done: got done=%b wr_ready=%b mem_we=%b want 1/0/0", done, wr_ready, mem_we);
                end
                n_done = n;
            end else begin
                wr_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                wr_data  = wr_words[k];
                #1;
                n_vec++;
                if (wr_ready !== 1'b1 || mem_we !== wr_valid || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_ctrl k=%0d: got wr_ready=%b mem_we=%b done=%b want 1/%b/0",
                             k, wr_ready, mem_we, done, wr_valid);
                end
                if (wr_valid) begin
                    n_vec++;
                    if (mem_addr !== 13'(base * 8 + k) || mem_din !== wr_words[k]) begin
                        n_err++;
                        $display("FAIL wr_word k=%0d: got addr=%0d din=%h want addr=%0d din=%h",
                                 k, mem_addr, mem_din, base * 8 + k, wr_words[k]);
                    end
`ifdef RESP_ECC_EN
                    n_vec++;
                    if (mem_par_din !== model_ecc(wr_words[k])) begin
                        n_err++;
                        $display("FAIL wr_par k=%0d: got %h want %h", k, mem_par_din, model_ecc(wr_words[k]));
                    end
`else
                    n_vec++;
                    if (mem_par_din !== 7'h0) begin
                        n_err++;
                        $display("FAIL wr_par k=%0d: got %h want 0", k, mem_par_din);
                    end
`endif
                    ref_mem[base * 8 + k] = wr_words[k];
                    if (k == 0) n_first = n;
                    if (k == 7) n_lastw = n;
                    k++;
                end
            end
            if (n_done < 0) begin
                @(negedge clk);
                n++;
            end
        end
        wr_valid = 1'b0;
        if (n_done < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wr_timeout: got %0d words want 8", k);
        end
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL wr_after_done: got req_ready=%b done=%b want 1/0", req_ready, done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b0 || rd_last !== 1'b0 || wr_ready !== 1'b0 ||
            done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 13'd0 ||
            err_single !== 1'b0 || err_double !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rr=%b rv=%b rl=%b wr=%b dn=%b we=%b addr=%0d se=%b de=%b want 1 0 0 0 0 0 0 0 0",
                     req_ready, rd_valid, rd_last, wr_ready, done, mem_we, mem_addr, err_single, err_double);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || mem_addr !== 13'd0) begin
            n_err++;
            $display("FAIL reset_release: got req_ready=%b mem_addr=%0d want 1/0", req_ready, mem_addr);
        end
    endtask

    task automatic test_read_fill;
        int f0, l, d;
        load_exp(1);
        do_read(32'h0000_0020, 0, f0, l, d);
        n_vec++;
        if (f0 != 2 || l != 16 || d != 17) begin
            n_err++;
            $display("FAIL rd_timing: got first=%0d last=%0d done=%0d want 2/16/17", f0, l, d);
        end
    endtask

    task automatic test_write_line;
        int f, l, d, f0, l0, d0;
        for (int k = 0; k < 8; k++) wr_words[k] = 32'hA0 + 32'(k);
        do_write(32'h0000_7FE4, 0, -1, f, l, d);
        n_vec++;
        if (f != 1 || l != 8 || d != 9) begin
            n_err++;
            $display("FAIL wr_timing: got first=%0d last=%0d done=%0d want 1/8/9", f, l, d);
        end
        // read the line straight back, back to back
        load_exp(1023);
        do_read(32'h0000_7FFC, 0, f0, l0, d0);
        n_vec++;
        if (d0 != 17) begin
            n_err++;
            $display("FAIL wr_readback_timing: got done=%0d want 17", d0);
        end
    endtask

    task automatic test_stall;
        int f0, l, d;
        load_exp(3);
        do_read(32'h0000_006C, 1, f0, l, d);
        n_vec++;
        if (f0 != 2 || d != 22) begin
            n_err++;
            $display("FAIL stall_timing: got first=%0d done=%0d want 2/22", f0, d);
        end
    endtask

    task automatic test_reset_mid_write;
        int f, l, d, f0, l0, d0;
        for (int k = 0; k < 8; k++) wr_words[k] = $urandom;
        do_write(32'h0000_00A0, 0, 4, f, l, d);
        wr_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1 || wr_ready !== 1'b0 ||
            mem_addr !== 13'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_write: got we=%b rr=%b wr=%b addr=%0d done=%b want 0 1 0 0 0",
                     mem_we, req_ready, wr_ready, mem_addr, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);
        // first four words were written, the rest keep the old contents
        load_exp(5);
        do_read(32'h0000_00B8, 0, f0, l0, d0);
        n_vec++;
        if (f0 != 2 || d0 != 17) begin
            n_err++;
            $display("FAIL reset_then_read: got first=%0d done=%0d want 2/17", f0, d0);
        end
    endtask

    task automatic test_random;
        int f, l, d, line;
        logic [31:0] addr;
        for (int t = 0; t < 16; t++) begin
            line = int'($urandom_range(0, 15));
            addr = {17'h0, 10'(line), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) wr_words[k] = $urandom;
                do_write(addr, 2, -1, f, l, d);
            end else begin
                load_exp(line);
                do_read(addr, 2, f, l, d);
            end
        end
    endtask

`ifdef RESP_ECC_EN
    task automatic test_ecc;
        int f0, l, d;
        flip_addr = 13'd18;
        flip_mask = 32'h0000_0020;
        load_exp(2);
        exp_se[2] = 1'b1;
        do_read(32'h0000_0040, 0, f0, l, d);
        n_vec++;
        if (d != 17) begin
            n_err++;
            $display("FAIL ecc_single_done: got done=%0d want 17", d);
        end
        flip_mask = 32'h0000_0220;
        load_exp(2);
        exp_data[2] = ref_mem[18] ^ 32'h0000_0220;
        exp_de[2]   = 1'b1;
        do_read(32'h0000_0044, 0, f0, l, d);
        n_vec++;
        if (d != 17) begin
            n_err++;
            $display("FAIL ecc_double_done: got done=%0d want 17", d);
        end
        flip_mask = 32'h0;
    endtask
`endif

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        rd_ready  = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 32'h0;
        bd_we     = 1'b0;
        bd_addr   = 13'h0;
        bd_data   = 32'h0;
        flip_addr = 13'h0;
        flip_mask = 32'h0;
        #2;
        test_reset;
        preload;
        @(negedge clk);
        test_read_fill;
        test_write_line;
        test_stall;
        test_reset_mid_write;
`ifdef RESP_ECC_EN
        test_ecc;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
